multi_period_timer: RTL and testbench
=====================================

// Module: multi_period_timer
// PURPOSE
//   Parametrised, multi-channel successor to the single-period ms counter.
//   A shared prescaler divides clk down to a base tick (default 1 ms at 100 MHz).
//   CH independent channels count base ticks against their own programmable period.
//   Each channel runs in periodic or one-shot mode and emits a one-cycle expiry pulse.
//   Feeds game/UI timing: blink rates, timeouts and countdowns in the top level.
// PARAMETERS
//   CLK_FREQ_HZ  100_000_000  input clock frequency
//   TICK_HZ      1000         base tick rate; DIV = CLK_FREQ_HZ/TICK_HZ, DIV >= 1 (integer)
//   CH           4            number of channels, >= 1
//   PW           16           period/count width per channel
// PORTS
//   clk         in   1      system clock
//   rst         in   1      synchronous reset, active-high
//   tick_en     in   1      global run enable; low freezes prescaler (channels hold)
//   ch_start    in   CH     per-channel start/restart strobe
//   ch_stop     in   CH     per-channel stop strobe
//   ch_oneshot  in   CH     mode, sampled at start: 1 = one-shot, 0 = periodic
//   period      in   CH*PW  channel i period in ticks at [i*PW +: PW], sampled at start
//   tick_out    out  1      one-cycle base tick pulse
//   ch_pulse    out  CH     one-cycle expiry pulse per channel
//   ch_busy     out  CH     channel in RUN
//   ch_count    out  CH*PW  elapsed ticks in current period, channel i at [i*PW +: PW]
// BEHAVIOUR
//   Reset: sync on rst=1. Prescaler=0, all channels IDLE; period_lat, count, mode = 0.
//     All outputs 0. Reset mid-run aborts every channel; no pulse is issued.
//   Prescaler: counts 0..DIV-1 while tick_en=1; holds while tick_en=0.
//     tick_out (registered) = 1 for one cycle after prescaler wraps (DIV-1 -> 0).
//     First tick_out is cycle DIV after reset release. DIV=1: tick_out each cycle.
//   Channel FSM, two states, per channel:
//     IDLE: busy=0, count held at 0.
//     RUN:  busy=1.
//   Priority each cycle: stop > start > tick.
//     stop: go to IDLE, count <= 0, no pulse. Legal in either state.
//     start with period slice != 0: period_lat <= slice, mode <= ch_oneshot[i],
//       count <= 0, go to RUN. Any tick in the same cycle is ignored.
//       Also legal in RUN (restart).
//     start with period slice == 0: ignored; state unchanged.
//     tick_out=1 in RUN, count == period_lat-1:
//       count <= 0; ch_pulse[i] <= 1 next cycle.
//       Periodic stays in RUN; one-shot goes to IDLE, busy falls same cycle as pulse.
//     tick_out=1 in RUN otherwise: count <= count+1.
//   Latency: start at cycle t -> busy=1 at t+1.
//     Pulse lands 1 cycle after the P-th tick_out following start.
//   Width: count/period_lat PW bits; period max 2**PW-1; count never exceeds period-1.
//   ch_pulse and tick_out are registered single-cycle pulses, never stretched.
//   Channels are fully independent; simultaneous expiries on several channels are allowed.
// TESTING  (CLK_FREQ_HZ=10, TICK_HZ=1 -> DIV=10, CH=2, PW=8)
//   1 Reset, tick_en=1 -> tick_out high at cycles 10,20,30 only; all other outputs 0.
//   2 ch0 periodic, period=3 -> ch_pulse[0] 1 cycle after tick 3,6,9; busy[0] stays 1;
//     ch_count[0] goes 0,1,2,0.
//   3 ch1 one-shot, period=2 -> single ch_pulse[1] after tick 2; busy[1]=0 that cycle;
//     no pulse after tick 4.
//   4 Start with period=0 -> busy stays 0, no pulse. start+stop same cycle -> stays IDLE.
//   5 ch0 period=4 restarted after 2 ticks -> ch_count[0]=0; next pulse 4 ticks after restart.
//   6 tick_en=0 for 25 cycles mid-count -> no tick_out, counts frozen, resume exactly.
//     rst mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/multi_period_timer.sv
// ---------------------------------------------------------------------------
// multi_period_timer
//   A shared prescaler divides clk down to a base tick (tick_out). CH
//   independent channels count base ticks against their own programmable
//   period, in periodic or one-shot mode, and emit a one-cycle expiry pulse.
//
// Handshake/strobe semantics: ch_start/ch_stop are single-cycle strobes
//   sampled on every rising clk edge; there is no back-pressure. Per channel
//   the priority is stop > start (non-zero period) > tick. A start with a
//   zero period slice is ignored entirely.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   tick_en     global run enable; low freezes the prescaler
//   ch_start    per-channel start/restart strobe
//   ch_stop     per-channel stop strobe
//   ch_oneshot  per-channel mode sampled at start (1 = one-shot)
//   period      channel i period in ticks at [i*PW +: PW], sampled at start
//   tick_out    one-cycle base tick pulse
//   ch_pulse    one-cycle expiry pulse per channel
//   ch_busy     channel is in RUN (FSM state exposed for observation)
//   ch_count    elapsed ticks in current period, channel i at [i*PW +: PW]
// ---------------------------------------------------------------------------
module multi_period_timer #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int CH          = 4,
   parameter int PW          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_en,
   input  logic [CH-1:0]    ch_start,
   input  logic [CH-1:0]    ch_stop,
   input  logic [CH-1:0]    ch_oneshot,
   input  logic [CH*PW-1:0] period,
   output logic             tick_out,
   output logic [CH-1:0]    ch_pulse,
   output logic [CH-1:0]    ch_busy,
   output logic [CH*PW-1:0] ch_count
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   // A divide-by-one prescaler still needs a 1-bit register to stay legal.
   localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PSW-1:0] PS_LAST = PSW'(DIV - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // ---------------- prescaler ----------------
   logic [PSW-1:0] presc_q, presc_d;
   logic           tick_q, tick_d;

   always_comb begin
      presc_d = presc_q;
      tick_d  = 1'b0;
      if (tick_en) begin
         if (presc_q == PS_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + PSW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign tick_out = tick_q;

   // ---------------- channels ----------------
   state_t                 state_q [CH];
   state_t                 state_d [CH];
   logic [CH-1:0][PW-1:0]  count_q, count_d;
   logic [CH-1:0][PW-1:0]  per_q, per_d;
   logic [CH-1:0]          mode_q, mode_d;
   logic [CH-1:0]          pulse_q, pulse_d;

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         count_d[i] = count_q[i];
         per_d[i]   = per_q[i];
         mode_d[i]  = mode_q[i];
         pulse_d[i] = 1'b0;

         if (ch_stop[i]) begin
            state_d[i] = S_IDLE;
            count_d[i] = '0;
         end else if (ch_start[i] && (period[i*PW +: PW] != '0)) begin
            // A tick coinciding with a (re)start is deliberately dropped.
            state_d[i] = S_RUN;
            count_d[i] = '0;
            per_d[i]   = period[i*PW +: PW];
            mode_d[i]  = ch_oneshot[i];
         end else if ((state_q[i] == S_RUN) && tick_q) begin
            if (count_q[i] == per_q[i] - PW'(1)) begin
               count_d[i] = '0;
               pulse_d[i] = 1'b1;
               // One-shot drops busy in the same cycle the pulse appears.
               if (mode_q[i]) begin
                  state_d[i] = S_IDLE;
               end
            end else begin
               count_d[i] = count_q[i] + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= S_IDLE;
         end
         count_q <= '0;
         per_q   <= '0;
         mode_q  <= '0;
         pulse_q <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
         end
         count_q <= count_d;
         per_q   <= per_d;
         mode_q  <= mode_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         ch_busy[i]            = (state_q[i] == S_RUN);
         ch_count[i*PW +: PW]  = count_q[i];
      end
   end

   assign ch_pulse = pulse_q;

endmodule

// File: tb/tb_multi_period_timer.sv
module tb_multi_period_timer;

  localparam int DIV = 10;
  localparam int CH  = 2;
  localparam int PW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tick_en = 1'b0;
  logic [CH-1:0]  ch_start = '0;
  logic [CH-1:0]  ch_stop = '0;
  logic [CH-1:0]  ch_oneshot = '0;
  logic [CH*PW-1:0] period = '0;
  logic           tick_out;
  logic [CH-1:0]  ch_pulse;
  logic [CH-1:0]  ch_busy;
  logic [CH*PW-1:0] ch_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  multi_period_timer #(
    .CLK_FREQ_HZ(10), .TICK_HZ(1), .CH(CH), .PW(PW)
  ) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .ch_start(ch_start),
    .ch_stop(ch_stop), .ch_oneshot(ch_oneshot), .period(period),
    .tick_out(tick_out), .ch_pulse(ch_pulse), .ch_busy(ch_busy),
    .ch_count(ch_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Timing is tracked as "enabled cycles since reset" and "ticks seen since
  // start"; count and expiry fall out of modular arithmetic on those totals.
  int m_e;
  bit m_tick;
  bit m_run [CH];
  int m_n [CH];
  int m_p [CH];
  bit m_os [CH];
  bit m_pulse [CH];

  task automatic model_update();
    bit new_tick;
    if (rst) begin
      m_e = 0; m_tick = 0;
      for (int i = 0; i < CH; i++) begin
        m_run[i] = 0; m_n[i] = 0; m_p[i] = 0; m_os[i] = 0; m_pulse[i] = 0;
      end
    end else begin
      new_tick = 0;
      if (tick_en) begin
        m_e++;
        if (m_e % DIV == 0) new_tick = 1;
      end
      for (int i = 0; i < CH; i++) begin
        int slice;
        slice = int'(period[i*PW +: PW]);
        m_pulse[i] = 0;
        if (ch_stop[i]) begin
          m_run[i] = 0; m_n[i] = 0;
        end else if (ch_start[i] && slice != 0) begin
          m_run[i] = 1; m_n[i] = 0; m_p[i] = slice; m_os[i] = ch_oneshot[i];
        end else if (m_run[i] && m_tick) begin
          m_n[i]++;
          if (m_n[i] % m_p[i] == 0) m_pulse[i] = 1;
          if (m_os[i] && m_n[i] == m_p[i]) begin
            m_run[i] = 0; m_n[i] = 0;
          end
        end
      end
      m_tick = new_tick;
    end
  endtask

  function automatic logic [20:0] exp_vec();
    logic [7:0] c0, c1;
    c0 = m_run[0] ? 8'(m_n[0] % m_p[0]) : 8'd0;
    c1 = m_run[1] ? 8'(m_n[1] % m_p[1]) : 8'd0;
    return {m_tick, m_pulse[1], m_pulse[0], m_run[1], m_run[0], c1, c0};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock: the model sees the same inputs the DUT samples, then
  // strobes are cleared #1 after the edge, where outputs are also sampled.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    ch_start = '0;
    ch_stop  = '0;
    cyc++;
  endtask

  task automatic start_ch(input int ch, input int p, input bit os);
    period[ch*PW +: PW] = 8'(p);
    ch_oneshot[ch] = os;
    ch_start[ch] = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; tick_en = 1;
    step(); step();
    checks++;
    if ({tick_out, ch_pulse, ch_busy, ch_count} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {tick_out, ch_pulse, ch_busy, ch_count}, 21'd0);
    end
    rst = 0;
    for (int i = 1; i <= 35; i++) begin
      step();
      checks++;
      if (tick_out !== ((i % DIV) == 0)) begin
        errors++;
        $display("FAIL tick_timing cyc_after_rst=%0d got=%b exp=%b", i, tick_out, (i % DIV) == 0);
      end
      checks++;
      if ({ch_pulse, ch_busy, ch_count} !== 20'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got=%h exp=0", cyc, {ch_pulse, ch_busy, ch_count});
      end
    end
  endtask

  task automatic test_periodic();
    int pulses;
    pulses = 0;
    start_ch(0, 3, 0);
    for (int i = 0; i < 100; i++) begin
      step();
      if (ch_pulse[0]) pulses++;
      checks++;
      if ({tick_out, ch_pulse, ch_busy, ch_count} !== exp_vec()) begin
        errors++;
        $display("FAIL periodic cyc=%0d got=%h exp=%h", cyc, {tick_out, ch_pulse, ch_busy, ch_count}, exp_vec());
      end
      checks++;
      if (ch_busy[0] !== 1'b1 || ch_count[7:0] > 8'd2) begin
        errors++;
        $display("FAIL periodic_busy_range cyc=%0d busy=%b count=%0d exp busy=1 count<=2", cyc, ch_busy[0], ch_count[7:0]);
      end
    end
    // 100 cycles hold exactly 10 ticks -> 3 full periods
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL periodic_pulse_count got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_oneshot();
    int pulses;
    pulses = 0;
    start_ch(1, 2, 1);
    for (int i = 0; i < 60; i++) begin
      step();
      if (ch_pulse[1]) begin
        pulses++;
        checks++;
        if (ch_busy[1] !== 1'b0) begin
          errors++;
          $display("FAIL oneshot_busy_at_pulse got=%b exp=0", ch_busy[1]);
        end
      end
      checks++;
      if ({tick_out, ch_pulse, ch_busy, ch_count} !== exp_vec()) begin
        errors++;
        $display("FAIL oneshot cyc=%0d got=%h exp=%h", cyc, {tick_out, ch_pulse, ch_busy, ch_count}, exp_vec());
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL oneshot_pulse_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_zero_and_conflict();
    ch_stop = 2'b11;
    step();
    start_ch(0, 0, 0);
    step();
    start_ch(1, 5, 0);
    ch_stop[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (ch_busy !== 2'b00 || ch_pulse !== 2'b00) begin
        errors++;
        $display("FAIL zero_or_conflict cyc=%0d busy=%b pulse=%b exp 00/00", cyc, ch_busy, ch_pulse);
      end
      checks++;
      if ({tick_out, ch_pulse, ch_busy, ch_count} !== exp_vec()) begin
        errors++;
        $display("FAIL zero_model cyc=%0d got=%h exp=%h", cyc, {tick_out, ch_pulse, ch_busy, ch_count}, exp_vec());
      end
    end
  endtask

  task automatic test_restart();
    int ticks, budget;
    bit seen;
    start_ch(0, 4, 0);
    step();
    budget = 0;
    while (ch_count[7:0] != 8'd2 && budget < 60) begin
      step();
      budget++;
    end
    checks++;
    if (ch_count[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL restart_reach2 got=%0d exp=2", ch_count[7:0]);
    end
    start_ch(0, 4, 0);
    step();
    checks++;
    if (ch_count[7:0] !== 8'd0 || ch_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear count=%0d busy=%b exp 0/1", ch_count[7:0], ch_busy[0]);
    end
    ticks = 0; seen = 0; budget = 0;
    while (!seen && budget < 80) begin
      step();
      budget++;
      if (ch_pulse[0]) seen = 1;
      else if (tick_out) ticks++;
    end
    checks++;
    if (!seen || ticks != 4) begin
      errors++;
      $display("FAIL restart_next_pulse seen=%b ticks=%0d exp seen=1 ticks=4", seen, ticks);
    end
  endtask

  task automatic test_freeze();
    logic [15:0] saved;
    int budget;
    budget = 0;
    while (ch_count[7:0] == 8'd0 && budget < 60) begin
      step();
      budget++;
    end
    step();
    saved = ch_count;
    tick_en = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      checks++;
      if (tick_out !== 1'b0 || ch_count !== saved) begin
        errors++;
        $display("FAIL freeze cyc=%0d tick=%b count=%h exp tick=0 count=%h", cyc, tick_out, ch_count, saved);
      end
    end
    tick_en = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if ({tick_out, ch_pulse, ch_busy, ch_count} !== exp_vec()) begin
        errors++;
        $display("FAIL resume cyc=%0d got=%h exp=%h", cyc, {tick_out, ch_pulse, ch_busy, ch_count}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midrun();
    start_ch(1, 3, 0);
    step(); step();
    rst = 1;
    step();
    checks++;
    if ({tick_out, ch_pulse, ch_busy, ch_count} !== 21'd0) begin
      errors++;
      $display("FAIL reset_midrun got=%h exp=0", {tick_out, ch_pulse, ch_busy, ch_count});
    end
    rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick_en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < CH; c++) begin
        period[c*PW +: PW] = 8'($urandom_range(0, 5));
        ch_oneshot[c] = 1'($urandom_range(0, 1));
        ch_start[c] = ($urandom_range(0, 19) == 0);
        ch_stop[c]  = ($urandom_range(0, 59) == 0);
      end
      step();
      checks++;
      if ({tick_out, ch_pulse, ch_busy, ch_count} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {tick_out, ch_pulse, ch_busy, ch_count}, exp_vec());
      end
    end
    rst = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_zero_and_conflict();
    test_restart();
    test_freeze();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
